// File: rtl/iob_wb2iob_pipe.sv
// iob_wb2iob_pipe: pipelined Wishbone B4 slave to IOb master bridge with request FIFO and timeout.
module iob_wb2iob_pipe #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REQ_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                wb_rst_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic                wb_stall_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i
);
  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(REQ_DEPTH);
  localparam int EW = ADDR_W + DATA_W + SW;
  localparam logic [15:0] TO = 16'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, ORPHAN} state_t;
  typedef struct packed {
    state_t            st;
    logic              abort;
    logic [15:0]       tcnt;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW:0]       cnt;
    logic              valid;
    logic              ack;
    logic              err;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic [SW-1:0]     wstrb;
    logic [DATA_W-1:0] rdat;
  } regs_t;
  regs_t r_q, r_d;
  logic [EW-1:0] mem_q [REQ_DEPTH];
  logic [EW-1:0] in_e, src_e;
  logic push, empty, tmo, done, issue, flush, wr, rd;
  assign wb_stall_o = r_q.cnt == (PW+1)'(REQ_DEPTH);
  assign wb_ack_o   = r_q.ack;
  assign wb_err_o   = r_q.err;
  assign wb_dat_o   = r_q.rdat;
  assign valid_o    = r_q.valid;
  assign address_o  = r_q.adr;
  assign wdata_o    = r_q.wdata;
  assign wstrb_o    = r_q.wstrb;
  // An empty FIFO is bypassed so a request issues the cycle after acceptance;
  // a completing transfer hands the IOb port straight to the next request.
  always_comb begin
    in_e  = {wb_adr_i, wb_dat_i, wb_we_i ? wb_sel_i : SW'(0)};
    empty = r_q.cnt == '0;
    src_e = empty ? in_e : mem_q[r_q.rptr];
    push  = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    tmo   = TO != 16'd0 && r_q.tcnt == TO;
    done  = r_q.st == BUSY && ready_i;
    issue = wb_cyc_i & (r_q.st == IDLE | done) & (~empty | push);
    flush = ~wb_cyc_i & (~empty | r_q.st != IDLE);
    wr    = push & ~(issue & empty);
    rd    = issue & ~empty;
    r_d = r_q;
    r_d.valid = issue;
    r_d.ack   = done & wb_cyc_i & ~r_q.abort;
    r_d.err   = r_q.st == BUSY & ~ready_i & tmo & wb_cyc_i & ~r_q.abort;
    r_d.rdat  = r_d.ack ? rdata_i : r_d.err ? '0 : r_q.rdat;
    r_d.wptr  = r_q.wptr + PW'(wr);
    r_d.rptr  = flush ? r_q.wptr : r_q.rptr + PW'(rd);
    r_d.cnt   = flush ? '0 : r_q.cnt + (PW+1)'(wr) - (PW+1)'(rd);
    r_d.st    = issue ? BUSY
              : r_q.st == BUSY ? (ready_i ? IDLE : tmo ? ORPHAN : BUSY)
              : r_q.st == ORPHAN ? ((ready_i | tmo) ? IDLE : ORPHAN)
              : IDLE;
    r_d.tcnt  = (!issue && r_d.st == r_q.st && r_q.st != IDLE) ? r_q.tcnt + 16'd1 : '0;
    r_d.abort = (issue || r_d.st == IDLE) ? 1'b0 : r_q.abort | ~wb_cyc_i;
    if (issue) {r_d.adr, r_d.wdata, r_d.wstrb} = src_e;
    if (wb_rst_i) r_d = '0;
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) r_q <= '0;
    else r_q <= r_d;
  always_ff @(posedge clk_i)
    if (wr) mem_q[r_q.wptr] <= in_e;
endmodule
